// File: rtl/logo_motion_sched.sv
// Move-strobe scheduler for the bouncing-logo mover: per-frame strobe bursts,
// speed level, pause/single-step control and edge/corner bounce accounting.
module logo_motion_sched #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int MAX_LEVEL   = 7,
    parameter int RESET_LEVEL = 0,
    parameter int GAP_CYC     = 1
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_pause,
    input  logic        btn_step,
    input  logic [9:0]  logo_x,
    input  logic [9:0]  logo_y,
    input  logic [9:0]  logo_length,
    input  logic [9:0]  logo_hight,
    output logic        move_en,
    output logic [2:0]  speed_level,
    output logic        paused,
    output logic [15:0] bounce_cnt,
    output logic        corner_hit
);

    localparam logic [2:0] MAX_LVL = 3'(MAX_LEVEL);
    localparam logic [2:0] RST_LVL = 3'(RESET_LEVEL);
    localparam logic [3:0] GAP_LEN = 4'(GAP_CYC);
    localparam logic [9:0] H_BOUND = 10'(H_RES);
    localparam logic [9:0] V_BOUND = 10'(V_RES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_remaining;
    logic [3:0]  w_remaining_nxt;
    logic [3:0]  r_gap_cnt;
    logic [3:0]  w_gap_cnt_nxt;
    logic        w_step_use;
    logic        w_move_en;

    logic        r_up_prev;
    logic        r_down_prev;
    logic        r_pause_prev;
    logic        r_step_prev;
    logic        r_paused;
    logic        r_step_armed;
    logic [2:0]  r_speed;
    logic [15:0] r_bounce_cnt;
    logic        r_corner;

    logic        w_up_edge;
    logic        w_down_edge;
    logic        w_pause_edge;
    logic        w_step_edge;
    logic        w_pause_enter;
    logic [9:0]  w_right_bound;
    logic [9:0]  w_bottom_bound;
    logic        w_x_edge;
    logic        w_y_edge;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            sat_inc16 = val;
        end else begin
            sat_inc16 = val + 16'd1;
        end
    endfunction

    assign w_up_edge     = btn_up & ~r_up_prev;
    assign w_down_edge   = btn_down & ~r_down_prev;
    assign w_pause_edge  = btn_pause & ~r_pause_prev;
    assign w_step_edge   = btn_step & ~r_step_prev;
    assign w_pause_enter = w_pause_edge & ~r_paused;

    assign w_right_bound  = H_BOUND - logo_length;
    assign w_bottom_bound = V_BOUND - logo_hight;
    assign w_x_edge = (logo_x == 10'd1) || (logo_x == w_right_bound);
    assign w_y_edge = (logo_y == 10'd1) || (logo_y == w_bottom_bound);

    assign speed_level = r_speed;
    assign paused      = r_paused;
    assign bounce_cnt  = r_bounce_cnt;
    assign corner_hit  = r_corner;
    assign move_en     = w_move_en;

    // Previous-level registers for button rising-edge detection
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_up_prev    <= 1'b0;
            r_down_prev  <= 1'b0;
            r_pause_prev <= 1'b0;
            r_step_prev  <= 1'b0;
        end else begin
            r_up_prev    <= btn_up;
            r_down_prev  <= btn_down;
            r_pause_prev <= btn_pause;
            r_step_prev  <= btn_step;
        end
    end

    // Saturating speed level; simultaneous up and down cancel
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_speed <= RST_LVL;
        end else if (w_up_edge && !w_down_edge && (r_speed != MAX_LVL)) begin
            r_speed <= r_speed + 3'd1;
        end else if (w_down_edge && !w_up_edge && (r_speed != 3'd0)) begin
            r_speed <= r_speed - 3'd1;
        end else begin
            r_speed <= r_speed;
        end
    end

    // Pause toggle and single-step arming; an edge arriving while a step is consumed stays armed
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_paused     <= 1'b0;
            r_step_armed <= 1'b0;
        end else begin
            r_paused <= r_paused ^ w_pause_edge;
            if (w_pause_edge && r_paused) begin
                r_step_armed <= 1'b0;
            end else if (w_step_edge && r_paused) begin
                r_step_armed <= 1'b1;
            end else if (w_step_use) begin
                r_step_armed <= 1'b0;
            end else begin
                r_step_armed <= r_step_armed;
            end
        end
    end

    // Burst FSM state register
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= 4'd0;
            r_gap_cnt   <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
        end
    end

    // Burst FSM next state; frame_start restarts from any state, entering pause aborts
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_step_use      = 1'b0;
        if (w_pause_enter) begin
            w_state_nxt     = ST_IDLE;
            w_remaining_nxt = 4'd0;
        end else if (frame_start) begin
            if (!r_paused) begin
                w_state_nxt     = ST_BURST;
                w_remaining_nxt = {1'b0, r_speed} + 4'd1;
            end else if (r_step_armed) begin
                w_state_nxt     = ST_BURST;
                w_remaining_nxt = 4'd1;
                w_step_use      = 1'b1;
            end else begin
                w_state_nxt     = ST_IDLE;
                w_remaining_nxt = 4'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_BURST: begin
                    w_remaining_nxt = r_remaining - 4'd1;
                    if (r_remaining <= 4'd1) begin
                        w_state_nxt = ST_IDLE;
                    end else if (GAP_LEN == 4'd0) begin
                        w_state_nxt = ST_BURST;
                    end else begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = GAP_LEN - 4'd1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == 4'd0) begin
                        w_state_nxt = ST_BURST;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_remaining_nxt = 4'd0;
                end
            endcase
        end
    end

    // Burst FSM output decode
    always_comb begin
        if (r_state == ST_BURST) begin
            w_move_en = 1'b1;
        end else begin
            w_move_en = 1'b0;
        end
    end

    // Bounce accounting on strobe cycles; a corner counts once and pulses corner_hit
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_bounce_cnt <= 16'd0;
            r_corner     <= 1'b0;
        end else begin
            r_corner <= w_move_en & w_x_edge & w_y_edge;
            if (w_move_en && (w_x_edge || w_y_edge)) begin
                r_bounce_cnt <= sat_inc16(r_bounce_cnt);
            end else begin
                r_bounce_cnt <= r_bounce_cnt;
            end
        end
    end

endmodule

// File: tb/tb_logo_motion_sched.sv
// Scoreboard bench for logo_motion_sched: expected strobe and corner cycles
// are queued when stimulus is driven and popped as the DUT produces them.
module tb_logo_motion_sched;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_pause = 1'b0;
    logic        btn_step = 1'b0;
    logic [9:0]  logo_x = 10'd300;
    logic [9:0]  logo_y = 10'd200;
    logic [9:0]  logo_length = 10'd64;
    logic [9:0]  logo_hight = 10'd32;
    logic        move_en;
    logic [2:0]  speed_level;
    logic        paused;
    logic [15:0] bounce_cnt;
    logic        corner_hit;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int exp_q[$];
    int corner_q[$];

    logo_motion_sched dut (
        .pclk        (pclk),
        .rst         (rst),
        .frame_start (frame_start),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_pause   (btn_pause),
        .btn_step    (btn_step),
        .logo_x      (logo_x),
        .logo_y      (logo_y),
        .logo_length (logo_length),
        .logo_hight  (logo_hight),
        .move_en     (move_en),
        .speed_level (speed_level),
        .paused      (paused),
        .bounce_cnt  (bounce_cnt),
        .corner_hit  (corner_hit)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    // Scoreboard: every strobe / corner pulse must match the next queued cycle
    always @(negedge pclk) begin
        if (move_en !== 1'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL move_en_unexpected: strobe at cycle %0d, none expected", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc !== e) begin
                    n_bad++;
                    $display("FAIL move_en_timing: strobe at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end
        if (corner_hit !== 1'b0) begin
            n_cmp++;
            if (corner_q.size() == 0) begin
                n_bad++;
                $display("FAIL corner_unexpected: corner_hit at cycle %0d, none expected", cyc);
            end else begin
                int e;
                e = corner_q.pop_front();
                if (cyc !== e) begin
                    n_bad++;
                    $display("FAIL corner_timing: corner_hit at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end
    end

    // Run n cycles; frame_start is high during the first one when fs is set
    task automatic run(input bit fs, input int n);
        frame_start = fs;
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            frame_start = 1'b0;
        end
    endtask

    task automatic press(input int b);
        case (b)
            0:       btn_up = 1'b1;
            1:       btn_down = 1'b1;
            2:       btn_pause = 1'b1;
            3:       btn_step = 1'b1;
            default: btn_up = 1'b0;
        endcase
        @(negedge pclk);
        btn_up = 1'b0; btn_down = 1'b0; btn_pause = 1'b0; btn_step = 1'b0;
        @(negedge pclk);
    endtask

    task automatic push_burst(input int start, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(start + 2 * k);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run(1'b0, 3);
        n_cmp++;
        if ({move_en, speed_level, paused, bounce_cnt, corner_hit} !== {1'b0, 3'd0, 1'b0, 16'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: move=%0b speed=%0d paused=%0b bounce=%0h corner=%0b, expected all zero",
                     move_en, speed_level, paused, bounce_cnt, corner_hit);
        end
        rst = 1'b0;
        run(1'b0, 2);
    endtask

    task automatic test_single_rate();
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(cyc + 1);
            run(1'b1, 1000);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL single_rate_missing: %0d strobes outstanding, expected 0", exp_q.size());
        end
        n_cmp++;
        if ({speed_level, bounce_cnt} !== {3'd0, 16'd0}) begin
            n_bad++;
            $display("FAIL single_rate_state: speed=%0d bounce=%0h, expected 0 and 0", speed_level, bounce_cnt);
        end
    endtask

    task automatic test_speed();
        for (int i = 0; i < 3; i++) press(0);
        n_cmp++;
        if (speed_level !== 3'd3) begin
            n_bad++;
            $display("FAIL speed_up3: speed=%0d, expected 3", speed_level);
        end
        btn_up = 1'b1; btn_down = 1'b1;
        run(1'b0, 1);
        btn_up = 1'b0; btn_down = 1'b0;
        run(1'b0, 1);
        n_cmp++;
        if (speed_level !== 3'd3) begin
            n_bad++;
            $display("FAIL speed_up_down: speed=%0d, expected 3", speed_level);
        end
        push_burst(cyc + 1, 4);
        run(1'b1, 20);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL burst4_missing: %0d strobes outstanding, expected 0", exp_q.size());
        end
        for (int i = 0; i < 10; i++) press(0);
        n_cmp++;
        if (speed_level !== 3'd7) begin
            n_bad++;
            $display("FAIL speed_saturate: speed=%0d, expected 7", speed_level);
        end
        push_burst(cyc + 1, 8);
        run(1'b1, 30);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL burst8_missing: %0d strobes outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_pause_step();
        push_burst(cyc + 1, 3);
        run(1'b1, 5);
        btn_pause = 1'b1;
        run(1'b0, 1);
        btn_pause = 1'b0;
        run(1'b0, 20);
        n_cmp++;
        if ((paused !== 1'b1) || (exp_q.size() != 0)) begin
            n_bad++;
            $display("FAIL pause_abort: paused=%0b outstanding=%0d, expected 1 and 0", paused, exp_q.size());
        end
        run(1'b1, 30);
        press(3);
        exp_q.push_back(cyc + 1);
        run(1'b1, 30);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL step_missing: %0d strobes outstanding, expected 0", exp_q.size());
        end
        run(1'b1, 30);
        press(2);
        n_cmp++;
        if (paused !== 1'b0) begin
            n_bad++;
            $display("FAIL unpause: paused=%0b, expected 0", paused);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 4; i++) press(1);
        logo_x = 10'd1; logo_y = 10'd200;
        push_burst(cyc + 1, 4);
        run(1'b1, 20);
        n_cmp++;
        if ((bounce_cnt !== 16'd4) || (exp_q.size() != 0)) begin
            n_bad++;
            $display("FAIL bounce_edges: bounce=%0d outstanding=%0d, expected 4 and 0", bounce_cnt, exp_q.size());
        end
        for (int i = 0; i < 3; i++) press(1);
        logo_y = 10'd1;
        exp_q.push_back(cyc + 1);
        corner_q.push_back(cyc + 2);
        run(1'b1, 10);
        n_cmp++;
        if ((bounce_cnt !== 16'd5) || (corner_q.size() != 0) || (speed_level !== 3'd0)) begin
            n_bad++;
            $display("FAIL bounce_corner: bounce=%0d corner_outstanding=%0d speed=%0d, expected 5, 0, 0",
                     bounce_cnt, corner_q.size(), speed_level);
        end
    endtask

    task automatic test_saturate();
        press(0); press(0);
        logo_x = 10'd1; logo_y = 10'd200;
        force dut.r_bounce_cnt = 16'hFFFE;
        run(1'b0, 1);
        release dut.r_bounce_cnt;
        run(1'b0, 1);
        n_cmp++;
        if (bounce_cnt !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL preload: bounce=%0h, expected fffe", bounce_cnt);
        end
        push_burst(cyc + 1, 3);
        run(1'b1, 2);
        n_cmp++;
        if (bounce_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_first: bounce=%0h, expected ffff", bounce_cnt);
        end
        run(1'b0, 10);
        n_cmp++;
        if (bounce_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_nowrap: bounce=%0h, expected ffff", bounce_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        for (int i = 0; i < 6; i++) press(0);
        logo_x = 10'd300; logo_y = 10'd200;
        c = cyc;
        exp_q.push_back(c + 1);
        push_burst(c + 3, 8);
        run(1'b1, 2);
        run(1'b1, 40);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL restart_missing: %0d strobes outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        logo_x = 10'd1; logo_y = 10'd1;
        exp_q.push_back(cyc + 1);
        exp_q.push_back(cyc + 3);
        corner_q.push_back(cyc + 2);
        run(1'b1, 3);
        rst = 1'b1;
        run(1'b0, 1);
        n_cmp++;
        if ({move_en, speed_level, paused, bounce_cnt, corner_hit} !== {1'b0, 3'd0, 1'b0, 16'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_mid: move=%0b speed=%0d paused=%0b bounce=%0h corner=%0b, expected all zero",
                     move_en, speed_level, paused, bounce_cnt, corner_hit);
        end
        rst = 1'b0;
        run(1'b0, 20);
        n_cmp++;
        if ((exp_q.size() != 0) || (corner_q.size() != 0)) begin
            n_bad++;
            $display("FAIL reset_mid_queue: outstanding strobes=%0d corners=%0d, expected 0 and 0",
                     exp_q.size(), corner_q.size());
        end
    endtask

    initial begin
        @(negedge pclk);
        test_reset();
        test_single_rate();
        test_speed();
        test_pause_step();
        test_bounce();
        test_saturate();
        test_back_to_back();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/logo_motion_sched.md
Name: logo_motion_sched

Overview:
- Scheduler and controller for the bouncing-logo mover.
- Generates the mover's single-cycle move strobe: a per-frame burst of N strobes, where N is set by a user speed level.
- Handles pause and single-step from push-button inputs.
- Counts edge bounces and corner hits by checking the mover's position against the same screen bounds the mover uses.
- Sits between the VGA timing generator (frame_start) and the mover (move_en drives its speed_ctrl input).

Parameters:
- H_RES, 640, active width used for the right-edge bound (H_RES - logo_length).
- V_RES, 480, active height used for the bottom-edge bound (V_RES - logo_hight).
- MAX_LEVEL, 7, highest speed level; steps per frame = speed_level + 1.
- RESET_LEVEL, 0, speed level loaded at reset.
- GAP_CYC, 1, idle cycles between consecutive move_en pulses in a burst (range 0..15).

Ports:
- pclk  input  1  pixel clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- frame_start  input  1  one-cycle pulse at start of vertical blanking.
- btn_up  input  1  debounced level; rising edge raises the speed level.
- btn_down  input  1  debounced level; rising edge lowers the speed level.
- btn_pause  input  1  debounced level; rising edge toggles pause.
- btn_step  input  1  debounced level; rising edge arms one step while paused.
- logo_x  input  10  current logo x from the mover.
- logo_y  input  10  current logo y from the mover.
- logo_length  input  10  logo width.
- logo_hight  input  10  logo height.
- move_en  output  1  one-cycle move strobe to the mover.
- speed_level  output  3  current speed level.
- paused  output  1  high while paused.
- bounce_cnt  output  16  saturating count of edge contacts.
- corner_hit  output  1  one-cycle pulse on a corner contact.

Behaviour:
- Reset, sampled on the pclk rising edge with rst=1:
  - move_en=0, speed_level=RESET_LEVEL, paused=0, bounce_cnt=0, corner_hit=0.
  - step_armed=0, edge-detect registers=0, FSM=IDLE.
  - rst asserted mid-burst kills the burst: no move_en in the cycle after rst is sampled.
- Edge detection: one register per button. A rising edge is btn=1 while prev=0. Edge actions take effect at the same clock edge.
- Speed control:
  - Up edge increments speed_level, saturating at MAX_LEVEL.
  - Down edge decrements, saturating at 0.
  - Up and down edges in the same cycle: no change.
  - Burst length is latched at frame_start, so a change never alters a burst already in progress.
- Pause control:
  - Pause edge toggles paused.
  - Entering pause aborts the remaining burst: FSM goes to IDLE, and move_en is 0 from the next cycle.
  - Step edge while paused sets step_armed. Step edge while running is ignored.
  - Leaving pause clears step_armed.
- FSM states: IDLE, BURST, GAP.
  - IDLE, on frame_start:
    - Not paused: remaining = speed_level + 1, go to BURST.
    - Paused with step_armed=1: remaining = 1, clear step_armed, go to BURST.
    - Paused with step_armed=0: stay in IDLE.
  - BURST: move_en=1 for exactly this cycle; remaining decrements.
    - remaining becomes 0: go to IDLE.
    - Otherwise, GAP_CYC=0: stay in BURST (back-to-back strobes).
    - Otherwise, GAP_CYC>0: go to GAP.
  - GAP: count GAP_CYC cycles with move_en=0, then return to BURST.
  - frame_start arriving in BURST or GAP: discard the remainder and reload as in IDLE, so a new burst starts next cycle. Bursts never overlap.
- move_en is registered: it is high exactly when the state register equals BURST.
- Bounce accounting, evaluated in each cycle move_en=1:
  - xe = (logo_x==1) or (logo_x==H_RES-logo_length).
  - ye = (logo_y==1) or (logo_y==V_RES-logo_hight).
  - Bound subtractions are 10-bit unsigned.
  - xe or ye: bounce_cnt increments, saturating at 16'hFFFF.
  - xe and ye: corner_hit=1 on the following cycle only, and bounce_cnt increments once, not twice.
  - No accounting in cycles with move_en=0.

Test Plan:
- Reset with RESET_LEVEL=0, then 3 frame_start pulses 1000 cycles apart → exactly 1 move_en per frame, 1 cycle after each frame_start; speed_level=0, bounce_cnt=0.
- 3 btn_up edges, then frame_start with GAP_CYC=1 → 4 move_en pulses at frame_start+1, +3, +5, +7. Then 10 more btn_up edges → speed_level saturates at 7 and the next frame yields 8 pulses.
- Pause edge in the middle of an 8-pulse burst (after the 3rd pulse) → no further move_en and paused=1. Next frame_start → 0 pulses. btn_step edge then frame_start → exactly 1 pulse. A second frame_start without a step → 0 pulses.
- Hold logo_x=1, logo_y=200 with 4 strobes → bounce_cnt=4, corner_hit never high. Set logo_x=1, logo_y=1 with 1 strobe → bounce_cnt=5, corner_hit high for 1 cycle, one cycle after the strobe.
- Preload bounce_cnt to 16'hFFFE via a forced-edge run (or force), then 3 edge strobes → 16'hFFFF, no wrap. frame_start 2 cycles into a burst → old burst discarded and a new full burst starts with no overlap. rst mid-burst → all outputs return to reset values the next cycle.
